shift_reg_arbiter: RTL
======================

SHIFT_REG_ARBITER -- requirements
Module: shift_reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, shared register width in bits.
REQ-002 Parameter CNT_W, default 3, rotate-count width; maximum count is 2^CNT_W-1.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 command present.
REQ-006 req0_ready  output  1  requester 0 command accepted this cycle when valid&&ready.
REQ-007 req0_op  input  2  00 READ, 01 ROTR, 10 ROTL, 11 LOAD.
REQ-008 req0_data  input  WIDTH  LOAD value; ignored for other ops.
REQ-009 req0_count  input  CNT_W  rotate steps; ignored for READ and LOAD.
REQ-010 req1_valid, req1_ready, req1_op, req1_data, req1_count  same as requester 0, for requester 1.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  consumer takes result when rsp_valid&&rsp_ready.
REQ-013 rsp_id  output  1  requester index owning the result.
REQ-014 rsp_data  output  WIDTH  register contents after the command completes.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, EXEC and RESP.
REQ-017 In IDLE, reqN_ready SHALL be asserted combinationally only for the requester granted this cycle; never for both.
REQ-018 Grant: one valid requester wins; if both are valid, the requester not granted last wins (round-robin).
REQ-019 On acceptance, the FSM SHALL latch op, data, count and id, then go to EXEC.
REQ-020 LOAD SHALL write data into the register in the first EXEC cycle, then go to RESP.
REQ-021 READ, and ROTR/ROTL with count 0, SHALL leave the register unchanged and spend one cycle in EXEC.
REQ-022 ROTR with count n>0 SHALL rotate right by one bit per EXEC cycle for n cycles (bit0 wraps to bit WIDTH-1); RESP follows the nth rotation.
REQ-023 ROTL mirrors ROTR (bit WIDTH-1 wraps to bit0).
REQ-024 Accept-to-rsp_valid latency SHALL be max(n,1)+1 cycles.
REQ-025 In RESP, rsp_valid SHALL be high with rsp_id/rsp_data stable until rsp_ready; the FSM then returns to IDLE.
REQ-026 No new command SHALL be accepted in EXEC or RESP; the earliest next accept is the cycle after the RESP handshake.
REQ-027 The shift register SHALL hold its value between commands and is shared by both requesters.

Reset
REQ-028 Reset SHALL override all other activity in the same cycle, including mid-EXEC and mid-RESP; the in-flight command is dropped without a response.
REQ-029 Reset values: state IDLE, register 0, rsp_valid 0, rsp_id 0, rsp_data 0, busy 0, last-grant pointer 1 (requester 0 has first priority), rotate counter 0.

Structure
REQ-030 A shared package SHALL hold the op encodings (READ/ROTR/ROTL/LOAD) and the FSM state enumeration.
REQ-031 The register datapath SHALL be one sub-module, shreg_core (WIDTH-bit, modes hold/rotate-right/rotate-left/load, rotates its own contents); the arbiter and FSM stay in the top module.

Verification
REQ-032 After reset, req0 LOAD 4'b1001 -> rsp_valid 2 cycles after accept, rsp_id 0, rsp_data 4'b1001.
REQ-033 Register 4'b1001, req1 ROTR count 1 -> rsp_data 4'b1100; then ROTL count 3 -> 4'b0110; latency 2 and 4 cycles.
REQ-034 Both valid in the same cycle after reset -> req0 granted first, req1 on the next IDLE; two simultaneous repeats alternate 1,0.
REQ-035 Hold rsp_ready low 5 cycles -> rsp_valid/rsp_data stable, both readies low, busy high throughout.
REQ-036 Assert reset in the 2nd EXEC cycle of ROTR count 5 -> next cycle IDLE, register 0, no rsp_valid.
REQ-037 READ and ROTR count 0 on register 4'b0101 -> rsp_data 4'b0101, latency 2 cycles each.

Source files
------------

// File: rtl/shift_reg_arbiter_pkg.sv
// Shared encodings for the two-requester shift-register arbiter.
package shift_reg_arbiter_pkg;

    // Command opcodes carried on reqN_op.
    typedef enum logic [1:0] {
        OP_READ = 2'b00,
        OP_ROTR = 2'b01,
        OP_ROTL = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    // Command FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Per-cycle operation applied to the shared register.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_ROTR = 2'b01,
        MODE_ROTL = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

endpackage

// File: rtl/shift_reg_arbiter_shreg_core.sv
// WIDTH-bit register that holds, rotates its own contents by one bit, or loads.
module shreg_core
    import shift_reg_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  mode_t            i_mode,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // One register update per cycle; reset clears the contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            case (i_mode)
                MODE_ROTR: r_q <= {r_q[0], r_q[WIDTH-1:1]};
                MODE_ROTL: r_q <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                MODE_LOAD: r_q <= i_data;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_reg_arbiter.sv
// Round-robin arbiter serialising two requesters' commands onto one shared
// shift register. Handshakes: a transfer happens in any cycle where valid and
// ready are both high at the rising clock edge; valid never depends on ready.
module shift_reg_arbiter
    import shift_reg_arbiter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [CNT_W-1:0] req0_count,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [CNT_W-1:0] req1_count,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last_grant;
    op_t              r_op;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             r_id;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_sel_id;
    mode_t            w_mode;
    logic             w_rotating;
    logic [WIDTH-1:0] w_q;

    // Round-robin: on contention the requester not granted last time wins.
    assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
    assign w_sel_id = w_grant1;
    assign w_rotating = ((r_op == OP_ROTR) || (r_op == OP_ROTL)) && (r_count != '0);

    // Next-state, grant and register-mode decode.
    always_comb begin
        w_state_next = r_state;
        w_mode       = MODE_HOLD;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = w_grant0;
                req1_ready = w_grant1;
                w_accept   = w_grant0 || w_grant1;
                if (w_accept) w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (r_op == OP_LOAD)                    w_mode = MODE_LOAD;
                else if (w_rotating && r_op == OP_ROTR) w_mode = MODE_ROTR;
                else if (w_rotating)                    w_mode = MODE_ROTL;
                // Stay in EXEC only while more than one rotation remains.
                if (!(w_rotating && r_count > 1)) w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Command latch, grant history and rotate-step counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_op         <= OP_READ;
            r_data       <= '0;
            r_count      <= '0;
            r_id         <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_sel_id;
            r_id         <= w_sel_id;
            r_op         <= op_t'(w_sel_id ? req1_op : req0_op);
            r_data       <= w_sel_id ? req1_data : req0_data;
            r_count      <= w_sel_id ? req1_count : req0_count;
        end else if (r_state == ST_EXEC) begin
            r_count <= (w_state_next == ST_RESP) ? '0 : r_count - 1'b1;
        end
    end

    shreg_core #(.WIDTH(WIDTH)) u_core (
        .clock  (clock),
        .reset  (reset),
        .i_mode (w_mode),
        .i_data (r_data),
        .o_q    (w_q)
    );

    // The register only changes in EXEC, so its output is the result in RESP.
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_id;
    assign rsp_data  = w_q;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule
